// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access op encodings, exception codes,
// FSM states and small decode helpers.
package lsu_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    EXC_NONE = 2'b00,
    EXC_ADEL = 2'b01,
    EXC_ADES = 2'b10
  } exc_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_MERGE,
    ST_DONE
  } state_e;

  function automatic logic is_store(op_e op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic logic is_misaligned(op_e op, logic [1:0] byte_off);
    logic bad;
    bad = 1'b0;
    case (op)
      OP_LW, OP_SW:         bad = (byte_off != 2'b00);
      OP_LH, OP_LHU, OP_SH: bad = byte_off[0];
      default:              bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane datapath: picks and extends the addressed lane of a loaded word, and
// splices store data into a previously read word for sub-word stores.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  byte_off,
  input  logic [31:0] load_word,
  input  logic [31:0] merge_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [4:0]  bit_off;

  always_comb begin
    bit_off  = {byte_off, 3'b000};
    byte_sel = load_word[bit_off +: 8];
    half_sel = byte_off[1] ? load_word[31:16] : load_word[15:0];

    load_data = load_word;
    case (op_e'(op))
      OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_data = {16'h0000, half_sel};
      OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_data = {24'h000000, byte_sel};
      default: load_data = load_word;
    endcase

    // Only the addressed lanes change; the rest of the read word passes through.
    merge_data = merge_word;
    case (op_e'(op))
      OP_SW: merge_data = wdata;
      OP_SH: begin
        if (byte_off[1]) merge_data[31:16] = wdata[15:0];
        else             merge_data[15:0]  = wdata[15:0];
      end
      OP_SB:   merge_data[bit_off +: 8] = wdata[7:0];
      default: merge_data = merge_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between a CPU request port and a word-wide synchronous-write data
// memory; sub-word stores use a read-modify-write through a merge register.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DM_AW = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [2:0]       op,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic             ready,
  output logic             done,
  output logic [31:0]      rdata,
  output logic [1:0]       exc,
  output logic [DM_AW-1:0] dm_addr,
  output logic [31:0]      dm_din,
  output logic             dm_we,
  input  logic [31:0]      dm_dout
);

  state_e             state, state_next;
  op_e                op_q;
  logic [DM_AW+1:0]   addr_q;
  logic [31:0]        wdata_q;
  logic [31:0]        merge_q;
  logic [31:0]        rdata_q;
  exc_e               exc_q;

  logic               addr_bad;
  exc_e               exc_new;
  logic [31:0]        load_data;
  logic [31:0]        merge_data;

  lsu_lane u_lane (
    .op         (op_q),
    .byte_off   (addr_q[1:0]),
    .load_word  (dm_dout),
    .merge_word (merge_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  // Address faults are decided from the incoming request so they skip the memory.
  always_comb begin
    addr_bad = is_misaligned(op_e'(op), addr[1:0]) || ((addr >> (DM_AW + 2)) != 32'd0);
    exc_new  = EXC_NONE;
    if (addr_bad) exc_new = is_store(op_e'(op)) ? EXC_ADES : EXC_ADEL;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    done       = 1'b0;
    dm_we      = 1'b0;
    dm_din     = '0;
    dm_addr    = '0;
    rdata      = '0;
    exc        = EXC_NONE;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (req) state_next = addr_bad ? ST_DONE : ST_ACCESS;
      end
      ST_ACCESS: begin
        dm_addr = addr_q[DM_AW+1:2];
        if (op_q == OP_SW) begin
          dm_we      = 1'b1;
          dm_din     = wdata_q;
          state_next = ST_DONE;
        end else if (is_store(op_q)) begin
          state_next = ST_MERGE;
        end else begin
          state_next = ST_DONE;
        end
      end
      ST_MERGE: begin
        dm_addr    = addr_q[DM_AW+1:2];
        dm_we      = 1'b1;
        dm_din     = merge_data;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        dm_addr    = addr_q[DM_AW+1:2];
        done       = 1'b1;
        rdata      = rdata_q;
        exc        = exc_q;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      op_q    <= OP_LW;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      exc_q   <= EXC_NONE;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE: begin
          if (req) begin
            op_q    <= op_e'(op);
            addr_q  <= addr[DM_AW+1:0];
            wdata_q <= wdata;
            rdata_q <= '0;
            exc_q   <= exc_new;
          end
        end
        ST_ACCESS: begin
          if (is_store(op_q)) merge_q <= dm_dout;
          else                rdata_q <= load_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed and random accesses against a
// byte-addressed reference memory, reset abort and back-to-back request handling.
module tb_load_store_unit;

  localparam int DM_AW     = 10;
  localparam int MEM_WORDS = 1 << DM_AW;
  localparam int MEM_BYTES = 4 * MEM_WORDS;

  localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3,
                         LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req;
  logic [2:0]       op;
  logic [31:0]      addr;
  logic [31:0]      wdata;
  logic             ready;
  logic             done;
  logic [31:0]      rdata;
  logic [1:0]       exc;
  logic [DM_AW-1:0] dm_addr;
  logic [31:0]      dm_din;
  logic             dm_we;
  logic [31:0]      dm_dout;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [MEM_WORDS];
  logic        preload;
  logic [7:0]  ref_bytes [MEM_BYTES];

  load_store_unit #(.DM_AW(DM_AW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .op      (op),
    .addr    (addr),
    .wdata   (wdata),
    .ready   (ready),
    .done    (done),
    .rdata   (rdata),
    .exc     (exc),
    .dm_addr (dm_addr),
    .dm_din  (dm_din),
    .dm_we   (dm_we),
    .dm_dout (dm_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    logic [31:0] x;
    x = 32'(i);
    return (x * 32'h9E3779B9) ^ 32'h5A5A1234;
  endfunction

  assign dm_dout = mem[dm_addr];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= init_word(i);
    end else if (dm_we) begin
      mem[dm_addr] <= dm_din;
    end
  end

  function automatic logic [31:0] ref_word(logic [31:0] a);
    int b;
    b = int'(a & ~32'd3);
    return {ref_bytes[b+3], ref_bytes[b+2], ref_bytes[b+1], ref_bytes[b]};
  endfunction

  // Reference: accesses as byte sequences in a little-endian byte array.
  task automatic model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w,
                          output logic [31:0] r, output logic [1:0] e, output int lat);
    int size;
    bit store;
    logic [31:0] v;
    store = (o == SW) || (o == SH) || (o == SB);
    size  = (o == LW || o == SW) ? 4 : (o == LH || o == LHU || o == SH) ? 2 : 1;
    r = 32'd0;
    e = 2'b00;
    if ((a % size) != 0 || a >= 32'(MEM_BYTES)) begin
      e   = store ? 2'b10 : 2'b01;
      lat = 1;
    end else if (store) begin
      for (int k = 0; k < size; k++) ref_bytes[int'(a) + k] = w[8*k +: 8];
      lat = (size == 4) ? 2 : 3;
    end else begin
      v = 32'd0;
      for (int k = 0; k < size; k++) v[8*k +: 8] = ref_bytes[int'(a) + k];
      if (o == LB) v = {{24{v[7]}}, v[7:0]};
      if (o == LH) v = {{16{v[15]}}, v[15:0]};
      r   = v;
      lat = 2;
    end
  endtask

  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w,
                       output logic [31:0] got);
    logic [31:0] er, exp_word;
    logic [1:0]  ee;
    int          el, cyc, we_n, we_cyc, exp_we_n;
    bit          in_range;
    model_op(o, a, w, er, ee, el);
    in_range = (a < 32'(MEM_BYTES));
    exp_word = in_range ? ref_word(a) : 32'd0;
    exp_we_n = ((o >= SW) && ee == 2'b00) ? 1 : 0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin errors++; $display("[TB] FAIL ready_idle: got %b expected 1", ready); end
    req = 1'b1; op = o; addr = a; wdata = w;
    @(negedge clk);
    req = 1'b0;
    cyc = 1; we_n = 0; we_cyc = 0;
    while (done !== 1'b1 && cyc < 8) begin
      checks++;
      if (ready !== 1'b0) begin errors++; $display("[TB] FAIL ready_busy: got %b expected 0 (op %0d addr %h)", ready, o, a); end
      if (dm_we === 1'b1) begin
        we_n++; we_cyc = cyc;
        checks++;
        if (dm_addr !== a[DM_AW+1:2]) begin errors++; $display("[TB] FAIL we_addr: got %h expected %h", dm_addr, a[DM_AW+1:2]); end
        checks++;
        if (dm_din !== exp_word) begin errors++; $display("[TB] FAIL we_data: got %h expected %h (op %0d addr %h)", dm_din, exp_word, o, a); end
      end
      @(negedge clk);
      cyc++;
    end
    got = rdata;
    checks++;
    if (done !== 1'b1) begin errors++; $display("[TB] FAIL done_timeout: got %b expected 1 (op %0d addr %h)", done, o, a); end
    checks++;
    if (cyc != el) begin errors++; $display("[TB] FAIL latency: got %0d expected %0d (op %0d addr %h)", cyc, el, o, a); end
    checks++;
    if (rdata !== er) begin errors++; $display("[TB] FAIL rdata: got %h expected %h (op %0d addr %h)", rdata, er, o, a); end
    checks++;
    if (exc !== ee) begin errors++; $display("[TB] FAIL exc: got %b expected %b (op %0d addr %h)", exc, ee, o, a); end
    checks++;
    if (dm_we !== 1'b0) begin errors++; $display("[TB] FAIL we_in_done: got %b expected 0", dm_we); end
    checks++;
    if (we_n != exp_we_n) begin errors++; $display("[TB] FAIL we_count: got %0d expected %0d (op %0d addr %h)", we_n, exp_we_n, o, a); end
    if (exp_we_n == 1) begin
      checks++;
      if (we_cyc != ((o == SW) ? 1 : 2)) begin errors++; $display("[TB] FAIL we_cycle: got %0d expected %0d", we_cyc, (o == SW) ? 1 : 2); end
    end
    if (in_range) begin
      checks++;
      if (mem[a[DM_AW+1:2]] !== exp_word) begin errors++; $display("[TB] FAIL mem_word: got %h expected %h (addr %h)", mem[a[DM_AW+1:2]], exp_word, a); end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || ready !== 1'b1) begin errors++; $display("[TB] FAIL done_pulse: got done=%b ready=%b expected done=0 ready=1", done, ready); end
  endtask

  task automatic check_window();
    for (int i = 32'h100; i < 32'h140; i += 4) begin
      checks++;
      if (mem[i/4] !== ref_word(32'(i))) begin errors++; $display("[TB] FAIL window_word: got %h expected %h (addr %h)", mem[i/4], ref_word(32'(i)), i); end
    end
  endtask

  function automatic logic [31:0] rand_addr(logic [2:0] o);
    int choice;
    logic [31:0] a;
    choice = $urandom_range(0, 99);
    if (choice < 70)      a = 32'h100 + 32'($urandom_range(0, 63));
    else if (choice < 85) a = 32'($urandom_range(0, MEM_BYTES - 1));
    else                  a = $urandom;
    if ($urandom_range(0, 3) != 0) begin
      if (o == LW || o == SW) a[1:0] = 2'b00;
      else if (o == LH || o == LHU || o == SH) a[0] = 1'b0;
    end
    return a;
  endfunction

  task automatic test_reset();
    #1;
    checks++;
    if (ready !== 1'b1 || done !== 1'b0) begin errors++; $display("[TB] FAIL reset_handshake: got ready=%b done=%b expected 1/0", ready, done); end
    checks++;
    if (rdata !== 32'd0 || exc !== 2'b00) begin errors++; $display("[TB] FAIL reset_result: got rdata=%h exc=%b expected 0/00", rdata, exc); end
    checks++;
    if (dm_we !== 1'b0 || dm_addr !== '0 || dm_din !== 32'd0) begin
      errors++; $display("[TB] FAIL reset_mem_port: got we=%b addr=%h din=%h expected 0/0/0", dm_we, dm_addr, dm_din);
    end
  endtask

  task automatic test_directed();
    logic [31:0] g;
    do_op(SW, 32'h10, 32'hDEADBEEF, g);
    do_op(LW, 32'h10, 32'h0, g);
    checks++;
    if (g !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL lw_deadbeef: got %h expected deadbeef", g); end
    do_op(SW, 32'h20, 32'h11223344, g);
    do_op(SB, 32'h22, 32'h000000AA, g);
    checks++;
    if (mem[8] !== 32'h11AA3344) begin errors++; $display("[TB] FAIL sb_merge: got %h expected 11aa3344", mem[8]); end
    do_op(LBU, 32'h22, 32'h0, g);
    checks++;
    if (g !== 32'h000000AA) begin errors++; $display("[TB] FAIL lbu: got %h expected 000000aa", g); end
    do_op(LB, 32'h22, 32'h0, g);
    checks++;
    if (g !== 32'hFFFFFFAA) begin errors++; $display("[TB] FAIL lb: got %h expected ffffffaa", g); end
    do_op(SW, 32'h20, 32'h11223344, g);
    do_op(SH, 32'h22, 32'h00008001, g);
    checks++;
    if (mem[8] !== 32'h80013344) begin errors++; $display("[TB] FAIL sh_merge: got %h expected 80013344", mem[8]); end
    do_op(LH, 32'h22, 32'h0, g);
    checks++;
    if (g !== 32'hFFFF8001) begin errors++; $display("[TB] FAIL lh: got %h expected ffff8001", g); end
    do_op(LHU, 32'h22, 32'h0, g);
    checks++;
    if (g !== 32'h00008001) begin errors++; $display("[TB] FAIL lhu: got %h expected 00008001", g); end
    do_op(LW, 32'h13, 32'h0, g);
    do_op(SH, 32'h2001, 32'h1234, g);
    do_op(SW, 32'h1000, 32'h55555555, g);
    do_op(LB, 32'h23, 32'h0, g);
    do_op(SB, 32'h103, 32'h000000C3, g);
    do_op(LBU, 32'h103, 32'h0, g);
  endtask

  task automatic test_random();
    logic [31:0] g;
    logic [2:0]  o;
    for (int n = 0; n < 300; n++) begin
      o = 3'($urandom_range(0, 7));
      do_op(o, rand_addr(o), $urandom, g);
    end
    check_window();
  endtask

  task automatic test_reset_abort();
    logic [31:0] g;
    do_op(SW, 32'h20, 32'h11223344, g);
    @(negedge clk);
    req = 1'b1; op = SB; addr = 32'h22; wdata = 32'h000000AA;
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (dm_we !== 1'b1) begin errors++; $display("[TB] FAIL abort_merge_we: got %b expected 1", dm_we); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (dm_we !== 1'b0) begin errors++; $display("[TB] FAIL abort_we_drop: got %b expected 0", dm_we); end
    checks++;
    if (ready !== 1'b1 || done !== 1'b0) begin errors++; $display("[TB] FAIL abort_state: got ready=%b done=%b expected 1/0", ready, done); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_no_done: got done=%b ready=%b expected 0/1", done, ready); end
    end
    checks++;
    if (mem[8] !== 32'h11223344) begin errors++; $display("[TB] FAIL abort_mem: got %h expected 11223344", mem[8]); end
  endtask

  task automatic test_back_to_back();
    localparam int N = 16;
    logic [2:0]  ops [N];
    logic [31:0] addrs [N];
    logic [31:0] wds [N];
    logic [31:0] ers [N];
    logic [1:0]  ees [N];
    int          lat, issued, fin, extra;
    bit          prev_done;
    for (int i = 0; i < N; i++) begin
      ops[i]   = 3'($urandom_range(0, 7));
      addrs[i] = rand_addr(ops[i]);
      wds[i]   = $urandom;
      model_op(ops[i], addrs[i], wds[i], ers[i], ees[i], lat);
    end
    issued = 0; fin = 0; prev_done = 1'b1;
    @(negedge clk);
    for (int cyc = 0; cyc < 200 && fin < N; cyc++) begin
      if (done === 1'b1) begin
        checks++;
        if (rdata !== ers[fin] || exc !== ees[fin]) begin
          errors++; $display("[TB] FAIL b2b_result[%0d]: got rdata=%h exc=%b expected rdata=%h exc=%b", fin, rdata, exc, ers[fin], ees[fin]);
        end
        fin++;
      end
      if (ready === 1'b1) begin
        checks++;
        if (!prev_done) begin errors++; $display("[TB] FAIL b2b_ready_gap: got ready=1 expected ready only after done"); end
        if (issued < N) begin
          req = 1'b1; op = ops[issued]; addr = addrs[issued]; wdata = wds[issued];
          issued++;
        end else begin
          req = 1'b0;
        end
      end
      prev_done = (done === 1'b1);
      @(negedge clk);
    end
    req = 1'b0;
    checks++;
    if (fin != N || issued != N) begin errors++; $display("[TB] FAIL b2b_count: got issued=%0d done=%0d expected %0d/%0d", issued, fin, N, N); end
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin errors++; $display("[TB] FAIL b2b_extra_done: got %0d expected 0", extra); end
    check_window();
  endtask

  initial begin
    rst_n   = 1'b0;
    preload = 1'b1;
    req     = 1'b0;
    op      = 3'd0;
    addr    = 32'd0;
    wdata   = 32'd0;
    for (int i = 0; i < MEM_WORDS; i++) begin
      logic [31:0] w;
      w = init_word(i);
      for (int k = 0; k < 4; k++) ref_bytes[4*i + k] = w[8*k +: 8];
    end
    test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    preload = 1'b0;
    rst_n   = 1'b1;
    test_directed();
    test_random();
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
